// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator SRAM port arbiter.
// Pure declarations: no latency, no flow control.
// Pipeline slot ids are ID_W bits wide, so up to four requesters fit.
package acc_mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;

    localparam int PORT_WB   = 0;
    localparam int PORT_IO   = 1;
    localparam int PORT_CORE = 2;

    localparam int ID_W = 2;

    // One stage of the read-return pipeline: live flag plus the port to answer.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_slot_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: per-port request lanes and the response broadcast.
// No storage: latency is set by the arbiter, and requests wait on req_rdy.
// Responses cannot be refused, so requesters must always accept resp_vld.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32
);

    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        resp_vld;
    logic [DATA_W-1:0]         resp_rdata;

    modport master (
        output req_vld,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_rdy,
        input  resp_vld,
        input  resp_rdata
    );

    modport slave (
        input  req_vld,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_rdy,
        output resp_vld,
        output resp_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first request at or above ptr, wrapping modulo N.
// Latency: purely combinational, the grant follows req and ptr in the same cycle.
// Backpressure: none; gnt is one-hot when any req is set, otherwise zero.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down, so the nearest hit to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters; round-robin, or WB_PORT first in debug mode.
// Latency: grant and SRAM drive in the accepting cycle; read data comes back READ_LATENCY cycles later.
// Backpressure: req_rdy stays low while a port loses arbitration or arb_en=0; responses cannot be stalled.
module mem_port_arbiter
    import acc_mem_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int WB_PORT      = PORT_WB,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prio_mode,
    input  logic              arb_en,
    mem_port_arbiter_if.slave bus,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int PTR_W = ID_W;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    logic               rd_xfer;
    logic               any_vld;
    rd_slot_t           new_slot;
    rd_slot_t           pipe [READ_LATENCY];
    rd_slot_t           pipe_out;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (bus.req_vld),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Debug priority overrides the rotation but never grants a port that is not asking.
    always_comb begin
        gnt = '0;
        if (rst_n && arb_en) begin
            if (prio_mode && bus.req_vld[WB_PORT]) begin
                gnt[WB_PORT] = 1'b1;
            end else begin
                gnt = rr_gnt;
            end
        end
    end

    assign bus.req_rdy = gnt;
    assign xfer        = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
    assign rd_xfer  = xfer & ~bus.req_we[gnt_idx];

    always_comb begin
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer) begin
            mem_csb   = 1'b0;
            mem_web   = ~bus.req_we[gnt_idx];
            mem_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            mem_wdata = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        new_slot.vld = rd_xfer;
        new_slot.id  = gnt_idx;
    end

    // The pipeline keeps shifting while arb_en=0 so in-flight reads still land.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= new_slot;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (xfer) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign pipe_out = pipe[READ_LATENCY-1];

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            any_vld = any_vld | pipe[i].vld;
        end
    end

    // Reset squashes a response that would otherwise surface during the reset cycle.
    always_comb begin
        bus.resp_vld = '0;
        if (rst_n && pipe_out.vld) begin
            bus.resp_vld[pipe_out.id] = 1'b1;
        end
    end

    assign bus.resp_rdata = mem_rdata;
    assign busy           = rst_n & any_vld;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with identical stimulus: directed scenarios, then random traffic.
// A transaction-level model (grant rule, pointer, list of accepted reads, memory image) predicts every output.
module tb_mem_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              prio_mode;
    logic              arb_en;
    logic [NR-1:0]     vld;
    logic [NR-1:0]     we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;

    logic          csb_a, web_a, busy_a, csb_b, web_b, busy_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    assign bus_a.req_vld   = vld;
    assign bus_a.req_we    = we;
    assign bus_a.req_addr  = addr;
    assign bus_a.req_wdata = wdata;
    assign bus_b.req_vld   = vld;
    assign bus_b.req_we    = we;
    assign bus_b.req_addr  = addr;
    assign bus_b.req_wdata = wdata;

    mem_port_arbiter #(.NUM_REQ(NR), .WB_PORT(0), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode), .arb_en(arb_en), .bus(bus_a.slave),
        .mem_csb(csb_a), .mem_web(web_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(rdata_a), .busy(busy_a)
    );

    mem_port_arbiter #(.NUM_REQ(NR), .WB_PORT(0), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode), .arb_en(arb_en), .bus(bus_b.slave),
        .mem_csb(csb_b), .mem_web(web_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata_b), .busy(busy_b)
    );

    function automatic logic [31:0] init_word(int a);
        return 32'h5A00_0000 ^ (a * 32'h0000_9E37);
    endfunction

    // SRAM macros: latency 1 for dut_a, latency 3 for dut_b; zero on non-read cycles.
    logic [31:0] sram_a [4096];
    logic [31:0] sram_b [4096];
    logic [31:0] rd_a = '0;
    logic [31:0] rd_b [3] = '{32'h0, 32'h0, 32'h0};
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                sram_a[i] <= init_word(i);
                sram_b[i] <= init_word(i);
            end
            mem_init <= 1'b1;
        end else begin
            if (!csb_a && !web_a) sram_a[addr_a] <= wdata_a;
            if (!csb_b && !web_b) sram_b[addr_b] <= wdata_b;
        end
        rd_a    <= (!csb_a && web_a) ? sram_a[addr_a] : 32'h0;
        rd_b[0] <= (!csb_b && web_b) ? sram_b[addr_b] : 32'h0;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end

    assign rdata_a = rd_a;
    assign rdata_b = rd_b[2];

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: pointer, memory image, and the list of accepted reads.
    typedef struct {
        int          acc;
        int          id;
        logic [31:0] data;
    } pend_t;

    pend_t       pq [$];
    int          m_ptr = 0;
    logic [31:0] ref_mem [4096];
    int          lat [2] = '{1, 3};

    function automatic int exp_grant();
        if (!rst_n || !arb_en) return -1;
        if (prio_mode && vld[0]) return 0;
        for (int k = 0; k < NR; k++) begin
            if (vld[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        int          g;
        logic [2:0]  e_rdy, e_rsp;
        logic [2:0]  o_rdy [2];
        logic [2:0]  o_rsp [2];
        logic        o_csb [2];
        logic        o_web [2];
        logic        o_busy [2];
        logic [11:0] o_addr [2];
        logic [31:0] o_wd [2];
        logic [31:0] o_rdat [2];
        logic [31:0] o_mrd [2];
        logic [11:0] e_addr;
        logic [31:0] e_wd, e_data;
        logic        e_busy;
        pend_t       item;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            o_rdy[0] = bus_a.req_rdy;   o_rdy[1] = bus_b.req_rdy;
            o_rsp[0] = bus_a.resp_vld;  o_rsp[1] = bus_b.resp_vld;
            o_rdat[0] = bus_a.resp_rdata; o_rdat[1] = bus_b.resp_rdata;
            o_csb[0] = csb_a;   o_csb[1] = csb_b;
            o_web[0] = web_a;   o_web[1] = web_b;
            o_addr[0] = addr_a; o_addr[1] = addr_b;
            o_wd[0] = wdata_a;  o_wd[1] = wdata_b;
            o_busy[0] = busy_a; o_busy[1] = busy_b;
            o_mrd[0] = rdata_a; o_mrd[1] = rdata_b;
            g      = exp_grant();
            e_rdy  = (g >= 0) ? (3'b001 << g) : 3'b000;
            e_addr = (g >= 0) ? addr[g*AW +: AW] : 12'h0;
            e_wd   = (g >= 0) ? wdata[g*DW +: DW] : 32'h0;
            for (int d = 0; d < 2; d++) begin
                e_rsp  = 3'b000;
                e_data = 32'h0;
                e_busy = 1'b0;
                foreach (pq[j]) begin
                    if (pq[j].acc + lat[d] == cyc) begin
                        e_rsp  = 3'b001 << pq[j].id;
                        e_data = pq[j].data;
                    end
                    if (pq[j].acc + lat[d] >= cyc) e_busy = 1'b1;
                end
                if (!rst_n) begin
                    e_rsp  = 3'b000;
                    e_busy = 1'b0;
                end
                check($sformatf("req_rdy%0d", d), 64'(o_rdy[d]), 64'(e_rdy));
                check($sformatf("mem_csb%0d", d), 64'(o_csb[d]), 64'(g < 0));
                check($sformatf("mem_web%0d", d), 64'(o_web[d]), 64'((g < 0) || !we[(g < 0) ? 0 : g]));
                check($sformatf("mem_addr%0d", d), 64'(o_addr[d]), 64'(e_addr));
                check($sformatf("mem_wdata%0d", d), 64'(o_wd[d]), 64'(e_wd));
                check($sformatf("resp_vld%0d", d), 64'(o_rsp[d]), 64'(e_rsp));
                check($sformatf("busy%0d", d), 64'(o_busy[d]), 64'(e_busy));
                check($sformatf("rdata_pass%0d", d), 64'(o_rdat[d]), 64'(o_mrd[d]));
                if (e_rsp != 3'b000) check($sformatf("resp_rdata%0d", d), 64'(o_rdat[d]), 64'(e_data));
            end
            while (pq.size() > 0 && pq[0].acc + 3 <= cyc) void'(pq.pop_front());
            if (!rst_n) begin
                m_ptr = 0;
                pq.delete();
            end else if (g >= 0) begin
                m_ptr = (g + 1) % NR;
                if (we[g]) begin
                    ref_mem[addr[g*AW +: AW]] = wdata[g*DW +: DW];
                end else begin
                    item.acc  = cyc;
                    item.id   = g;
                    item.data = ref_mem[addr[g*AW +: AW]];
                    pq.push_back(item);
                end
            end
            cyc++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [11:0] a, input logic [31:0] dat);
        we[p]            = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = dat;
    endtask

    initial begin
        rst_n = 1'b0; prio_mode = 1'b0; arb_en = 1'b1;
        vld = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) next();
        rst_n = 1'b1;

        // Reset mid-read: the port-1 read must never be answered.
        vld = 3'b010; set_port(1, 1'b0, 12'h010, 32'h0);
        @(negedge clk); check("rst_read_grant", 64'(bus_a.req_rdy), 64'h2);
        next();
        vld = 3'b000; rst_n = 1'b0;
        @(negedge clk); check("rst_no_resp", 64'(bus_a.resp_vld), 64'h0);
        next();
        rst_n = 1'b1;

        // Round-robin from a freshly reset pointer.
        vld = 3'b111; we = 3'b000;
        for (int i = 0; i < 7; i++) begin
            for (int p = 0; p < NR; p++) set_port(p, 1'b0, 12'($urandom_range(0, 4095)), 32'h0);
            @(negedge clk);
            check("rr_grant", 64'(bus_a.req_rdy), 64'(3'b001 << (i % 3)));
            if (i == 0) begin
                check("rst_busy_clear", 64'(busy_a), 64'h0);
                check("rst_resp_clear", 64'(bus_a.resp_vld), 64'h0);
            end else begin
                check("rr_resp", 64'(bus_a.resp_vld), 64'(3'b001 << ((i - 1) % 3)));
            end
            next();
        end

        // Debug priority, then rotation resumes after port 0.
        vld = 3'b101; prio_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("prio_grant", 64'(bus_a.req_rdy), 64'h1);
            next();
        end
        prio_mode = 1'b0;
        @(negedge clk); check("prio_release", 64'(bus_a.req_rdy), 64'h4);
        next();
        vld = 3'b000;
        repeat (4) next();

        // Write then read-back of the same word from another port.
        vld = 3'b100; set_port(2, 1'b1, 12'hABC, 32'hDEADBEEF);
        @(negedge clk); check("wr_web", 64'(web_a), 64'h0);
        next();
        vld = 3'b010; set_port(1, 1'b0, 12'hABC, 32'h0); we[2] = 1'b0;
        @(negedge clk); check("rd_web", 64'(web_a), 64'h1);
        next();
        vld = 3'b000;
        @(negedge clk);
        check("wr_rd_resp", 64'(bus_a.resp_vld), 64'h2);
        check("wr_rd_data", 64'(bus_a.resp_rdata), 64'hDEADBEEF);
        next();
        repeat (4) next();

        // arb_en gating with a read already in flight.
        vld = 3'b010; set_port(1, 1'b0, 12'h020, 32'h0);
        next();
        arb_en = 1'b0;
        @(negedge clk);
        check("en_rdy", 64'(bus_a.req_rdy), 64'h0);
        check("en_csb", 64'(csb_a), 64'h1);
        check("en_inflight_resp", 64'(bus_a.resp_vld), 64'h2);
        next();
        @(negedge clk); check("en_busy_drop", 64'(busy_a), 64'h0);
        next();
        arb_en = 1'b1; vld = 3'b000;
        repeat (4) next();

        // Latency 3: back-to-back reads from ports 1, 2, 0.
        for (int k = 0; k < 7; k++) begin
            vld = (k == 0) ? 3'b010 : (k == 1) ? 3'b100 : (k == 2) ? 3'b001 : 3'b000;
            if (k < 3) set_port((k + 1) % 3, 1'b0, 12'(16 * k + 5), 32'h0);
            @(negedge clk);
            if (k >= 1 && k <= 5) check("lat3_busy", 64'(busy_b), 64'h1);
            if (k == 6) check("lat3_idle", 64'(busy_b), 64'h0);
            if (k == 3) check("lat3_resp1", 64'(bus_b.resp_vld), 64'h2);
            if (k == 4) check("lat3_resp2", 64'(bus_b.resp_vld), 64'h4);
            if (k == 5) check("lat3_resp0", 64'(bus_b.resp_vld), 64'h1);
            next();
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            vld       = 3'($urandom);
            prio_mode = ($urandom_range(0, 3) == 0);
            arb_en    = ($urandom_range(0, 7) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < NR; p++) begin
                set_port(p, 1'($urandom), 12'($urandom_range(0, 31)), $urandom);
            end
            next();
        end
        rst_n = 1'b1; vld = 3'b000; arb_en = 1'b1; prio_mode = 1'b0;
        repeat (6) next();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
